// File: rtl/trace_buffer.sv
// Triggerable multi-channel event trace: per-channel holding slots feed a round-robin
// arbiter into a DEPTH-entry ring that freezes after POST_TRIG records and reads out oldest-first.
module trace_buffer #(
  parameter int NCH       = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 16,
  localparam int CH_W     = $clog2(NCH),
  localparam int DEPTH_W  = $clog2(DEPTH),
  localparam int REC_W    = CH_W + TS_W + DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  clear,
  input  logic                  trig,
  input  logic [NCH-1:0]        ch_valid,
  input  logic [NCH*DATA_W-1:0] ch_data,
  output logic [1:0]            state,
  output logic [NCH-1:0]        drop,
  output logic [DEPTH_W:0]      count,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [REC_W-1:0]      rd_data
);

  localparam int CNT_W = DEPTH_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_TRIG);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_FROZEN    = 2'd3
  } state_t;

  state_t              state_q;
  logic [TS_W-1:0]     ts_q;
  logic [NCH-1:0]      slot_full;
  logic [NCH-1:0]      full_next;
  logic [NCH-1:0]      slot_load;
  logic [NCH-1:0]      drop_set;
  logic [NCH-1:0]      grant_oh;
  logic [NCH-1:0]      drop_q;
  logic [TS_W-1:0]     slot_ts   [NCH];
  logic [DATA_W-1:0]   slot_data [NCH];
  logic [REC_W-1:0]    ring      [DEPTH];
  logic [DEPTH_W-1:0]  wr_ptr;
  logic [DEPTH_W-1:0]  rd_addr;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     grant_id;
  logic [CH_W-1:0]     cand;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    post_q;
  logic                grant_vld;
  logic                cap_en;
  logic                wr_en;
  logic                freeze;
  logic                rd_fire;

  assign state = state_q;
  assign drop  = drop_q;
  assign count = count_q;

  assign cap_en  = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED);
  assign wr_en   = grant_vld && cap_en && !clear;
  assign freeze  = ((state_q == ST_ARMED) && trig && (POST_INIT == '0)) ||
                   ((state_q == ST_TRIGGERED) && wr_en && (post_q == CNT_W'(1)));
  assign rd_fire = (state_q == ST_FROZEN) && rd_en && (count_q != '0) && !clear;
  // Oldest record sits count entries behind the write pointer; reads shrink count.
  assign rd_addr = wr_ptr - count_q[DEPTH_W-1:0];

  // Round-robin: first full slot at or after rr_ptr.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NCH);
      if (!grant_vld && slot_full[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    full_next = slot_full;
    slot_load = '0;
    drop_set  = '0;
    grant_oh  = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_oh[i]  = wr_en && (grant_id == CH_W'(i));
      slot_load[i] = cap_en && ch_valid[i] && (!slot_full[i] || grant_oh[i]);
      drop_set[i]  = cap_en && ch_valid[i] && slot_full[i] && !grant_oh[i];
      if (freeze)            full_next[i] = 1'b0;
      else if (slot_load[i]) full_next[i] = 1'b1;
      else if (grant_oh[i])  full_next[i] = 1'b0;
    end
  end

  // NOTE: slot payloads and the ring have no reset; slot_full and count say what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (slot_load[i]) begin
        slot_ts[i]   <= ts_q;
        slot_data[i] <= ch_data[i*DATA_W +: DATA_W];
      end
    end
    if (wr_en) ring[wr_ptr] <= {grant_id, slot_ts[grant_id], slot_data[grant_id]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ts_q      <= '0;
      slot_full <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      post_q    <= '0;
      wr_ptr    <= '0;
      rr_ptr    <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      ts_q     <= ts_q + 1'b1;
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= ring[rd_addr];
      if (clear) begin
        state_q   <= ST_IDLE;
        slot_full <= '0;
        drop_q    <= '0;
        count_q   <= '0;
        post_q    <= '0;
        wr_ptr    <= '0;
        rr_ptr    <= '0;
      end else begin
        slot_full <= full_next;
        drop_q    <= drop_q | drop_set;
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          rr_ptr <= (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;
          if (count_q != FULL_CNT) count_q <= count_q + 1'b1;
        end else if (rd_fire) begin
          count_q <= count_q - 1'b1;
        end
        // A write in the trigger cycle is pre-trigger history, so post only counts in TRIGGERED.
        case (state_q)
          ST_IDLE: if (arm) state_q <= ST_ARMED;
          ST_ARMED: begin
            if (trig) begin
              post_q  <= POST_INIT;
              state_q <= freeze ? ST_FROZEN : ST_TRIGGERED;
            end
          end
          ST_TRIGGERED: begin
            if (wr_en) begin
              post_q <= post_q - 1'b1;
              if (freeze) state_q <= ST_FROZEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a cycle table on a POST_TRIG=0 instance plus hand
// sequences for wrap, post-trigger freeze, clear priority, timestamp wrap and async reset.
module tb_trace_buffer;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        arm      = 1'b0;
  logic        clear    = 1'b0;
  logic        trig     = 1'b0;
  logic        rd_en    = 1'b0;
  logic [3:0]  ch_valid = '0;
  logic [63:0] ch_data  = '0;

  logic [1:0]  state0, state3;
  logic [3:0]  drop0, drop3, count0, count3;
  logic        rv0, rv3;
  logic [33:0] rd0;
  logic [21:0] rd3;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int last_cyc;

  trace_buffer #(.NCH(4), .DATA_W(16), .DEPTH(8), .TS_W(16), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .trig(trig),
    .ch_valid(ch_valid), .ch_data(ch_data), .state(state0), .drop(drop0),
    .count(count0), .rd_en(rd_en), .rd_valid(rv0), .rd_data(rd0)
  );

  trace_buffer #(.NCH(4), .DATA_W(16), .DEPTH(8), .TS_W(4), .POST_TRIG(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .arm(arm), .clear(clear), .trig(trig),
    .ch_valid(ch_valid), .ch_data(ch_data), .state(state3), .drop(drop3),
    .count(count3), .rd_en(rd_en), .rd_valid(rv3), .rd_data(rd3)
  );

  always #5 clk = ~clk;

  // Reference timestamp: equals the DUT ts value during each cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic        arm, clr, trig, rd;
    logic [3:0]  vld;
    logic [63:0] data;
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic [3:0]  drp;
    logic        rv;
    logic [33:0] rdat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int a, c, t, r, v, input logic [63:0] d,
                     input int st, cnt, drp, rv, input logic [33:0] rdat);
    vec_t x;
    x.arm  = a[0];
    x.clr  = c[0];
    x.trig = t[0];
    x.rd   = r[0];
    x.vld  = 4'(v);
    x.data = d;
    x.st   = 2'(st);
    x.cnt  = 4'(cnt);
    x.drp  = 4'(drp);
    x.rv   = rv[0];
    x.rdat = rdat;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the next rising edge.
  task automatic tick(input int a, c, t, r, v, input logic [63:0] d);
    @(negedge clk);
    arm      = a[0];
    clear    = c[0];
    trig     = t[0];
    rd_en    = r[0];
    ch_valid = 4'(v);
    ch_data  = d;
    last_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] on_ch(input int ch, input logic [15:0] val);
    return 64'(val) << (16 * ch);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] abcd, efgh;
    logic [33:0] rec_a, rec_b, rec_c, rec_d, rec_e, rec_x;
    int ts_first, cap;

    abcd  = 64'h00D0_00C0_00B0_00A0;
    efgh  = 64'h0070_0060_00F0_00E0;
    rec_a = {2'd0, 16'd4, 16'h00A0};
    rec_b = {2'd1, 16'd4, 16'h00B0};
    rec_c = {2'd2, 16'd4, 16'h00C0};
    rec_d = {2'd3, 16'd4, 16'h00D0};
    rec_e = {2'd0, 16'd5, 16'h00E0};

    // Row k runs while ts == k+1; expected outputs are those seen after the row's edge.
    //   arm clr trg rd vld  data        st cnt drp rv rd_data
    add(0, 0, 0, 0, 0,   64'h0,       0, 0, 0,   0, 34'h0);
    add(0, 0, 0, 0, 1,   64'h11,      0, 0, 0,   0, 34'h0);
    add(1, 0, 0, 0, 0,   64'h0,       1, 0, 0,   0, 34'h0);
    add(0, 0, 0, 0, 15,  abcd,        1, 0, 0,   0, 34'h0);
    add(0, 0, 0, 0, 15,  efgh,        1, 1, 14,  0, 34'h0);
    add(0, 0, 0, 0, 0,   64'h0,       1, 2, 14,  0, 34'h0);
    add(0, 0, 0, 0, 0,   64'h0,       1, 3, 14,  0, 34'h0);
    add(0, 0, 0, 0, 0,   64'h0,       1, 4, 14,  0, 34'h0);
    add(0, 0, 0, 0, 0,   64'h0,       1, 5, 14,  0, 34'h0);
    add(0, 0, 0, 1, 0,   64'h0,       1, 5, 14,  0, 34'h0);
    add(0, 0, 1, 0, 0,   64'h0,       3, 5, 14,  0, 34'h0);
    add(0, 0, 0, 1, 0,   64'h0,       3, 4, 14,  1, rec_a);
    add(0, 0, 0, 1, 0,   64'h0,       3, 3, 14,  1, rec_b);
    add(0, 0, 0, 1, 0,   64'h0,       3, 2, 14,  1, rec_c);
    add(0, 0, 0, 1, 0,   64'h0,       3, 1, 14,  1, rec_d);
    add(0, 0, 0, 1, 0,   64'h0,       3, 0, 14,  1, rec_e);
    add(0, 0, 0, 1, 0,   64'h0,       3, 0, 14,  0, rec_e);
    add(1, 0, 1, 0, 0,   64'h0,       3, 0, 14,  0, rec_e);
    add(1, 1, 1, 1, 15,  abcd,        0, 0, 0,   0, rec_e);
    add(1, 0, 0, 0, 0,   64'h0,       1, 0, 0,   0, rec_e);

    repeat (3) @(negedge clk);
    check("reset.state", state0, 0);
    check("reset.count", count0, 0);
    check("reset.rd_valid", rv0, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].arm, vecs[i].clr, vecs[i].trig, vecs[i].rd, vecs[i].vld, vecs[i].data);
      check($sformatf("v%0d.state", i), state0, vecs[i].st);
      check($sformatf("v%0d.count", i), count0, vecs[i].cnt);
      check($sformatf("v%0d.drop", i), drop0, vecs[i].drp);
      check($sformatf("v%0d.rd_valid", i), rv0, vecs[i].rv);
      check($sformatf("v%0d.rd_data", i), rd0, vecs[i].rdat);
    end

    // Wrap: ch0 delivers 1..10, trigger three cycles after the last sample.
    ts_first = 0;
    for (int v = 1; v <= 10; v++) begin
      tick(0, 0, 0, 0, 1, 64'(v));
      if (v == 3) ts_first = last_cyc;
    end
    tick(0, 0, 0, 0, 0, 64'h0);
    tick(0, 0, 0, 0, 0, 64'h0);
    tick(0, 0, 1, 0, 0, 64'h0);
    check("wrap.state", state0, 3);
    check("wrap.count", count0, 8);
    check("wrap.drop", drop0, 0);
    for (int j = 0; j < 8; j++) begin
      tick(0, 0, 0, 1, 0, 64'h0);
      check($sformatf("wrap.rv%0d", j), rv0, 1);
      check($sformatf("wrap.rec%0d", j), rd0, {2'd0, 16'(ts_first + j), 16'(3 + j)});
    end
    tick(0, 0, 0, 0, 0, 64'h0);
    check("wrap.rv_end", rv0, 0);
    check("wrap.count_end", count0, 0);
    tick(0, 1, 0, 0, 0, 64'h0);

    // Post-trigger: ch1 supplies 20 samples, trigger with sample 10.
    tick(1, 0, 0, 0, 0, 64'h0);
    for (int n = 1; n <= 20; n++) begin
      tick(0, 0, (n == 10) ? 1 : 0, 0, 2, on_ch(1, 16'(100 + n)));
      if (n == 10) begin
        check("post.state0_trig", state0, 3);
        check("post.state3_trig", state3, 2);
      end
      if (n == 12) check("post.state3_s12", state3, 2);
      if (n == 13) check("post.state3_s13", state3, 3);
    end
    check("post.count0", count0, 8);
    check("post.count3", count3, 8);
    for (int j = 0; j < 8; j++) begin
      tick(0, 0, 0, 1, 0, 64'h0);
      check($sformatf("post.d0rec%0d", j), {rd0[33:32], rd0[15:0]}, {2'd1, 16'(102 + j)});
      check($sformatf("post.d3rec%0d", j), {rd3[21:20], rd3[15:0]}, {2'd1, 16'(105 + j)});
    end
    tick(0, 1, 0, 0, 0, 64'h0);

    // Timestamp wrap and read with an empty ring.
    tick(1, 0, 0, 0, 0, 64'h0);
    repeat (20) tick(0, 0, 0, 0, 0, 64'h0);
    tick(0, 0, 0, 0, 4, on_ch(2, 16'h0ABC));
    cap = last_cyc;
    tick(0, 0, 1, 0, 0, 64'h0);
    tick(0, 0, 0, 0, 8, on_ch(3, 16'd1));
    tick(0, 0, 0, 0, 8, on_ch(3, 16'd2));
    tick(0, 0, 0, 0, 8, on_ch(3, 16'd3));
    tick(0, 0, 0, 0, 0, 64'h0);
    check("tsw.state3", state3, 3);
    check("tsw.count3", count3, 4);
    check("tsw.state0", state0, 3);
    check("tsw.count0", count0, 1);
    tick(0, 0, 0, 1, 0, 64'h0);
    rec_x = {2'd2, 16'(cap), 16'h0ABC};
    check("tsw.rv3", rv3, 1);
    check("tsw.rec3", rd3, {2'd2, 4'(cap), 16'h0ABC});
    check("tsw.rv0", rv0, 1);
    check("tsw.rec0", rd0, rec_x);
    tick(0, 0, 0, 1, 0, 64'h0);
    check("empty.rv0", rv0, 0);
    check("empty.hold0", rd0, rec_x);
    check("empty.rv3", rv3, 1);
    check("empty.rec3", rd3[15:0], 16'd1);
    tick(0, 1, 0, 0, 0, 64'h0);

    // Clear wins over arm/trig/rd_en in TRIGGERED.
    tick(1, 0, 0, 0, 0, 64'h0);
    tick(0, 0, 0, 0, 3, on_ch(0, 16'd1) | on_ch(1, 16'd2));
    tick(0, 0, 0, 0, 2, on_ch(1, 16'd3));
    check("clr.drop_pre", drop3, 4'b0010);
    tick(0, 0, 1, 0, 0, 64'h0);
    check("clr.state_pre", state3, 2);
    check("clr.count_pre", count3, 2);
    tick(1, 1, 1, 1, 0, 64'h0);
    check("clr.state", state3, 0);
    check("clr.count", count3, 0);
    check("clr.drop", drop3, 0);
    check("clr.rv", rv3, 0);
    check("clr.state0", state0, 0);
    tick(1, 0, 0, 0, 0, 64'h0);
    check("clr.rearm", state3, 1);

    // Asynchronous reset in the middle of a capture.
    tick(0, 0, 0, 0, 15, {$urandom, $urandom});
    tick(0, 0, 0, 0, 15, {$urandom, $urandom});
    check("arst.drop_pre", drop3, 4'b1110);
    @(negedge clk);
    ch_valid = 4'($urandom);
    ch_data  = {$urandom, $urandom};
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.state0", state0, 0);
    check("arst.state3", state3, 0);
    check("arst.drop0", drop0, 0);
    check("arst.drop3", drop3, 0);
    check("arst.count0", count0, 0);
    check("arst.count3", count3, 0);
    check("arst.rv0", rv0, 0);
    check("arst.rv3", rv3, 0);
    check("arst.rd0", rd0, 0);
    check("arst.rd3", rd3, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick(0, 0, 0, 0, 15, {$urandom, $urandom});
    check("idle.state", state0, 0);
    check("idle.count0", count0, 0);
    check("idle.count3", count3, 0);
    check("idle.drop3", drop3, 0);
    tick(1, 0, 0, 0, 0, 64'h0);
    check("idle.arm", state0, 1);
    check("idle.arm_count", count0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
